// File: rtl/scr1_tb_mem2axi_pkg.sv
// scr1_tb_mem2axi_pkg: response/cmd/width enums, order-entry struct and AXI constants for the mem-to-AXI bridge
package scr1_tb_mem2axi_pkg;
  typedef enum logic [1:0] {RESP_IDLE = 2'b00, RESP_RDY = 2'b01, RESP_ER = 2'b10} resp_e;
  typedef enum logic {CMD_RD = 1'b0, CMD_WR = 1'b1} cmd_e;
  typedef enum logic [1:0] {WID_BYTE = 2'd0, WID_HALF = 2'd1, WID_WORD = 2'd2} width_e;
  typedef struct packed {
    cmd_e       cmd;
    logic       err;
    logic [1:0] off;
    width_e     width;
  } ord_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  function automatic logic [3:0] byte_mask(width_e w);
    return w == WID_BYTE ? 4'b0001 : w == WID_HALF ? 4'b0011 : 4'b1111;
  endfunction
endpackage

// File: rtl/scr1_tb_sync_fifo.sv
// scr1_tb_sync_fifo: synchronous FIFO with async active-high reset and full/empty flags
// Ports: clk, rst, push/din write side, pop/dout read side (dout shows the head), full, empty.
module scr1_tb_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  assign empty = wp == rp;
  assign full  = wp == {~rp[AW], rp[AW-1:0]};
  assign dout  = mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(push);
      rp <= rp + (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/scr1_tb_mem2axi_bridge.sv
// scr1_tb_mem2axi_bridge: SCR1 core memory interface to single-beat AXI4, responses returned in request order
// Ports: clk, rst (async, active high); core_req/ack/cmd/width/addr/wdata/rdata/resp core side;
// AW, W, B, AR, R AXI channels. Define SCR1_TB_MEM2AXI_ID_CHECK_EN to check bid/rid and rlast.
module scr1_tb_mem2axi_bridge #(
  parameter int DEPTH  = 4,
  parameter int W_ID   = 4,
  parameter int W_ADR  = 32,
  parameter int W_DATA = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                core_req,
  output logic                core_req_ack,
  input  logic                core_cmd,
  input  logic [1:0]          core_width,
  input  logic [W_ADR-1:0]    core_addr,
  input  logic [W_DATA-1:0]   core_wdata,
  output logic [W_DATA-1:0]   core_rdata,
  output logic [1:0]          core_resp,
  output logic                awvalid,
  input  logic                awready,
  output logic [W_ID-1:0]     awid,
  output logic [W_ADR-1:0]    awaddr,
  output logic [2:0]          awsize,
  output logic [7:0]          awlen,
  output logic                wvalid,
  input  logic                wready,
  output logic [W_DATA-1:0]   wdata,
  output logic [W_DATA/8-1:0] wstrb,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [W_ID-1:0]     bid,
  input  logic [1:0]          bresp,
  output logic                arvalid,
  input  logic                arready,
  output logic [W_ID-1:0]     arid,
  output logic [W_ADR-1:0]    araddr,
  output logic [1:0]          arburst,
  output logic [2:0]          arsize,
  output logic [7:0]          arlen,
  input  logic                rvalid,
  output logic                rready,
  input  logic [W_ID-1:0]     rid,
  input  logic [W_DATA-1:0]   rdata,
  input  logic                rlast,
  input  logic [1:0]          rresp
);
  import scr1_tb_mem2axi_pkg::*;
  logic [W_ID-1:0]   id_cnt;
  ord_t              ord_in, ord_out;
  logic              ord_full, ord_empty, ord_pop, b_full, b_empty, b_pop, r_full, r_empty, r_pop;
  logic              misalign, accept, issue, id_err;
  logic [1:0]        b_resp_q, r_resp_q, resp_n;
  logic [W_DATA-1:0] r_data_q, rdata_n, rmask;
  assign awlen   = AXI_LEN_SINGLE;
  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign wlast   = 1'b1;
  assign bready  = 1'b1;
  assign rready  = 1'b1;
  assign misalign = core_width == WID_HALF ? core_addr[0] : core_width == WID_WORD ? |core_addr[1:0] : 1'b0;
  assign core_req_ack = ~rst & ~ord_full & ~awvalid & ~wvalid & ~arvalid;
  assign accept = core_req & core_req_ack;
  // misaligned requests occupy an order slot but never reach AXI
  assign issue  = accept & ~misalign;
  assign ord_in = '{cmd: cmd_e'(core_cmd), err: misalign, off: core_addr[1:0], width: width_e'(core_width)};
`ifdef SCR1_TB_MEM2AXI_ID_CHECK_EN
  logic [W_ID-1:0] ord_id, b_id_q, r_id_q;
  logic [$bits(ord_t)+W_ID-1:0] ord_q;
  logic [2+W_ID-1:0] b_q;
  logic [2+W_DATA+W_ID-1:0] r_q;
  assign {ord_out, ord_id} = ord_q;
  assign {b_resp_q, b_id_q} = b_q;
  assign {r_resp_q, r_data_q, r_id_q} = r_q;
  scr1_tb_sync_fifo #(.W($bits(ord_t)+W_ID), .DEPTH(DEPTH)) i_ord (.clk(clk), .rst(rst), .push(accept), .pop(ord_pop),
    .din({ord_in, id_cnt}), .dout(ord_q), .full(ord_full), .empty(ord_empty));
  scr1_tb_sync_fifo #(.W(2+W_ID), .DEPTH(DEPTH)) i_b (.clk(clk), .rst(rst), .push(bvalid), .pop(b_pop),
    .din({bresp, bid}), .dout(b_q), .full(b_full), .empty(b_empty));
  scr1_tb_sync_fifo #(.W(2+W_DATA+W_ID), .DEPTH(DEPTH)) i_r (.clk(clk), .rst(rst), .push(rvalid), .pop(r_pop),
    .din({rresp, rdata, rid}), .dout(r_q), .full(r_full), .empty(r_empty));
  assign id_err = (b_pop & (b_id_q != ord_id)) | (r_pop & (r_id_q != ord_id));
  a_id: assert property (@(posedge clk) disable iff (rst) !id_err) else $error("MEM2AXI: id mismatch");
  a_rlast: assert property (@(posedge clk) disable iff (rst) rvalid |-> rlast);
`else
  logic [$bits(ord_t)-1:0] ord_q;
  logic [2+W_DATA-1:0] r_q;
  logic unused_ids;
  assign ord_out = ord_q;
  assign {r_resp_q, r_data_q} = r_q;
  assign unused_ids = ^{bid, rid, rlast};
  scr1_tb_sync_fifo #(.W($bits(ord_t)), .DEPTH(DEPTH)) i_ord (.clk(clk), .rst(rst), .push(accept), .pop(ord_pop),
    .din(ord_in), .dout(ord_q), .full(ord_full), .empty(ord_empty));
  scr1_tb_sync_fifo #(.W(2), .DEPTH(DEPTH)) i_b (.clk(clk), .rst(rst), .push(bvalid), .pop(b_pop),
    .din(bresp), .dout(b_resp_q), .full(b_full), .empty(b_empty));
  scr1_tb_sync_fifo #(.W(2+W_DATA), .DEPTH(DEPTH)) i_r (.clk(clk), .rst(rst), .push(rvalid), .pop(r_pop),
    .din({rresp, rdata}), .dout(r_q), .full(r_full), .empty(r_empty));
  assign id_err = 1'b0;
`endif
  a_b_ovf: assert property (@(posedge clk) disable iff (rst) !(bvalid && b_full));
  a_r_ovf: assert property (@(posedge clk) disable iff (rst) !(rvalid && r_full));
  // the head of the order FIFO decides which response channel may be drained this cycle
  assign ord_pop = ~ord_empty & (ord_out.err | (ord_out.cmd == CMD_WR ? ~b_empty : ~r_empty));
  assign b_pop   = ord_pop & ~ord_out.err & (ord_out.cmd == CMD_WR);
  assign r_pop   = ord_pop & ~ord_out.err & (ord_out.cmd == CMD_RD);
  assign resp_n  = ord_out.err | id_err ? RESP_ER : (b_pop ? b_resp_q : r_resp_q) == 2'b00 ? RESP_RDY : RESP_ER;
  assign rmask   = ord_out.width == WID_BYTE ? W_DATA'(32'hFF) : ord_out.width == WID_HALF ? W_DATA'(32'hFFFF) : '1;
  assign rdata_n = (r_data_q >> {ord_out.off, 3'b000}) & rmask;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      arvalid    <= 1'b0;
      id_cnt     <= '0;
      awid       <= '0;
      awaddr     <= '0;
      awsize     <= '0;
      wdata      <= '0;
      wstrb      <= '0;
      arid       <= '0;
      araddr     <= '0;
      arsize     <= '0;
      core_resp  <= RESP_IDLE;
      core_rdata <= '0;
    end else begin
      if (awready) awvalid <= 1'b0;
      if (wready) wvalid <= 1'b0;
      if (arready) arvalid <= 1'b0;
      if (issue) begin
        id_cnt <= id_cnt + 1'b1;
        if (core_cmd) begin
          awvalid <= 1'b1;
          wvalid  <= 1'b1;
          awid    <= id_cnt;
          awaddr  <= core_addr;
          awsize  <= {1'b0, core_width};
          wdata   <= core_wdata << {core_addr[1:0], 3'b000};
          wstrb   <= byte_mask(width_e'(core_width)) << core_addr[1:0];
        end else begin
          arvalid <= 1'b1;
          arid    <= id_cnt;
          araddr  <= core_addr;
          arsize  <= {1'b0, core_width};
        end
      end
      core_resp <= ord_pop ? resp_n : RESP_IDLE;
      if (r_pop) core_rdata <= rdata_n;
    end
endmodule

// File: tb/tb_scr1_tb_mem2axi_bridge.sv
// tb_scr1_tb_mem2axi_bridge: scoreboard bench for the mem-to-AXI bridge with a small AXI memory model
module tb_scr1_tb_mem2axi_bridge;
  logic clk = 1'b0, rst = 1'b1;
  logic core_req = 1'b0, core_req_ack, core_cmd = 1'b0;
  logic [1:0] core_width = '0, core_resp;
  logic [31:0] core_addr = '0, core_wdata = '0, core_rdata;
  logic awvalid, awready = 1'b1, wvalid, wready = 1'b1, wlast, bvalid = 1'b0, bready;
  logic arvalid, arready = 1'b1, rvalid = 1'b0, rready, rlast = 1'b1;
  logic [3:0] awid, bid = '0, arid, rid = '0, wstrb;
  logic [31:0] awaddr, wdata, araddr, rdata = '0;
  logic [2:0] awsize, arsize;
  logic [7:0] awlen, arlen;
  logic [1:0] bresp = '0, arburst, rresp = '0;
  always #5 clk = ~clk;
  scr1_tb_mem2axi_bridge dut (
    .clk(clk), .rst(rst), .core_req(core_req), .core_req_ack(core_req_ack), .core_cmd(core_cmd),
    .core_width(core_width), .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_resp(core_resp), .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awsize(awsize), .awlen(awlen), .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp), .arvalid(arvalid),
    .arready(arready), .arid(arid), .araddr(araddr), .arburst(arburst), .arsize(arsize), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rlast(rlast), .rresp(rresp));
  typedef struct {logic [1:0] resp; bit rd; logic [31:0] data;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [3:0] aw_id_q[$], ar_id_q[$], bq_id[$];
  logic [35:0] rq[$];
  logic [31:0] mem [256];
  int checks = 0, errors = 0, ar_cnt = 0;
  bit b_en = 1, r_en = 1, aw_p = 0, w_p = 0;
  logic [31:0] aw_a, w_d, last_wdata;
  logic [3:0] aw_i, w_s, last_wstrb, last_arid, eid, exp_id = '0;
  // AXI memory model: handshakes seen at the negedge complete at the following posedge
  always @(negedge clk)
    if (rst) begin
      bvalid = 0; rvalid = 0; aw_p = 0; w_p = 0;
      bq_id.delete(); rq.delete();
    end else begin
      bvalid = b_en && bq_id.size() > 0;
      if (bvalid) bid = bq_id.pop_front();
      rvalid = r_en && rq.size() > 0;
      if (rvalid) {rid, rdata} = rq.pop_front();
      if (awvalid && awready) begin
        eid = aw_id_q.size() > 0 ? aw_id_q.pop_front() : 4'hx;
        checks++;
        if ({awid, awlen} !== {eid, 8'd0}) begin errors++; $display("FAIL aw_fields got id %0h len %0d want id %0h len 0", awid, awlen, eid); end
        aw_p = 1; aw_a = awaddr; aw_i = awid;
      end
      if (wvalid && wready) begin
        checks++;
        if (wlast !== 1'b1) begin errors++; $display("FAIL wlast got %b want 1", wlast); end
        w_p = 1; w_d = wdata; w_s = wstrb;
      end
      if (aw_p && w_p) begin
        for (int i = 0; i < 4; i++) if (w_s[i]) mem[aw_a[9:2]][8*i +: 8] = w_d[8*i +: 8];
        last_wdata = w_d; last_wstrb = w_s;
        bq_id.push_back(aw_i);
        aw_p = 0; w_p = 0;
      end
      if (arvalid && arready) begin
        eid = ar_id_q.size() > 0 ? ar_id_q.pop_front() : 4'hx;
        checks++;
        if ({arid, arlen, arburst} !== {eid, 8'd0, 2'b01}) begin errors++; $display("FAIL ar_fields got id %0h len %0d burst %0d want id %0h len 0 burst 1", arid, arlen, arburst, eid); end
        ar_cnt++; last_arid = arid;
        rq.push_back({arid, mem[araddr[9:2]]});
      end
    end
  // scoreboard: every non-IDLE response must match the oldest expectation
  always @(negedge clk)
    if (!rst && core_resp !== 2'b00) begin
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL unexpected_resp got %0h want none", core_resp); end
      else begin
        mon_e = exp_q.pop_front();
        if (core_resp !== mon_e.resp || (mon_e.rd && mon_e.resp == 2'b01 && core_rdata !== mon_e.data)) begin
          errors++; $display("FAIL resp got %0h/%h want %0h/%h", core_resp, core_rdata, mon_e.resp, mon_e.data);
        end
      end
    end
  task automatic issue(input bit wr, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] er, input logic [31:0] ed);
    int n = 0;
    @(negedge clk);
    core_req = 1; core_cmd = wr; core_width = w; core_addr = a; core_wdata = d;
    #1;
    while (!core_req_ack && n < 100) begin @(negedge clk); #1; n++; end
    checks++;
    if (!core_req_ack) begin errors++; $display("FAIL req_ack got 0 want 1 addr %h", a); end
    else begin
      exp_q.push_back('{er, !wr, ed});
      if (er == 2'b01) begin
        if (wr) aw_id_q.push_back(exp_id);
        else ar_id_q.push_back(exp_id);
        exp_id++;
      end
    end
    @(posedge clk); #1;
    core_req = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin @(negedge clk); #2; n++; end
    checks++;
    if (exp_q.size() > 0) begin errors++; $display("FAIL drain got %0d pending want 0", exp_q.size()); end
  endtask
  task automatic idle_for(input int cyc, input string tag);
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk); #1;
      checks++;
      if (core_resp !== 2'b00) begin errors++; $display("FAIL %s got resp %0h want 0", tag, core_resp); end
    end
  endtask
  task automatic test_reset();
    @(negedge clk); #1;
    checks++;
    if ({awvalid, wvalid, arvalid, core_req_ack} !== 4'b0) begin errors++; $display("FAIL reset_valids got %b want 0000", {awvalid, wvalid, arvalid, core_req_ack}); end
    checks++;
    if (core_resp !== 2'b00 || core_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp got %0h/%h want 0/0", core_resp, core_rdata); end
    @(negedge clk);
    rst = 0;
  endtask
  task automatic test_word();
    issue(1, 2'd2, 32'h100, 32'h1234_5678, 2'b01, 32'h0);
    issue(0, 2'd2, 32'h100, 32'h0, 2'b01, 32'h1234_5678);
    drain();
    checks++;
    if (last_wstrb !== 4'hF || last_wdata !== 32'h1234_5678) begin errors++; $display("FAIL word_w got %h/%h want f/12345678", last_wstrb, last_wdata); end
  endtask
  task automatic test_byte_half();
    issue(1, 2'd0, 32'h103, 32'h0000_00AB, 2'b01, 32'h0);
    issue(0, 2'd1, 32'h102, 32'h0, 2'b01, 32'h0000_AB34);
    drain();
    checks++;
    if (last_wstrb !== 4'h8 || last_wdata !== 32'hAB00_0000) begin errors++; $display("FAIL byte_w got %h/%h want 8/ab000000", last_wstrb, last_wdata); end
  endtask
  task automatic test_back_to_back();
    r_en = 0;
    for (int i = 0; i < 4; i++) issue(0, 2'd2, 32'h110 + 4*i, 32'h0, 2'b01, 32'h1000_0044 + i);
    @(negedge clk);
    core_req = 1; core_cmd = 1; core_width = 2'd2; core_addr = 32'h120; core_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1; checks++;
      if (core_req_ack !== 1'b0) begin errors++; $display("FAIL full_ack got %b want 0", core_req_ack); end
      @(negedge clk);
    end
    core_req = 0; r_en = 1;
    issue(1, 2'd2, 32'h120, 32'hDEAD_BEEF, 2'b01, 32'h0);
    drain();
  endtask
  task automatic test_reorder();
    b_en = 0;
    issue(1, 2'd2, 32'h130, 32'h55AA_55AA, 2'b01, 32'h0);
    issue(0, 2'd2, 32'h114, 32'h0, 2'b01, 32'h1000_0045);
    idle_for(6, "reorder_hold");
    b_en = 1;
    drain();
  endtask
  task automatic test_misaligned();
    int c;
    r_en = 0; c = ar_cnt;
    issue(0, 2'd2, 32'h104, 32'h0, 2'b01, 32'h1000_0041);
    issue(0, 2'd1, 32'h101, 32'h0, 2'b10, 32'h0);
    idle_for(4, "misalign_hold");
    r_en = 1;
    drain();
    checks++;
    if (ar_cnt - c !== 1) begin errors++; $display("FAIL misalign_ar got %0d want 1", ar_cnt - c); end
  endtask
  task automatic test_reset_mid();
    b_en = 0; r_en = 0;
    issue(1, 2'd2, 32'h140, 32'h0BAD_F00D, 2'b01, 32'h0);
    issue(0, 2'd2, 32'h104, 32'h0, 2'b01, 32'h1000_0041);
    issue(0, 2'd2, 32'h108, 32'h0, 2'b01, 32'h1000_0042);
    @(negedge clk);
    rst = 1; #1;
    checks++;
    if ({awvalid, wvalid, arvalid, core_req_ack} !== 4'b0) begin errors++; $display("FAIL midrst_valids got %b want 0000", {awvalid, wvalid, arvalid, core_req_ack}); end
    checks++;
    if (core_resp !== 2'b00) begin errors++; $display("FAIL midrst_resp got %0h want 0", core_resp); end
    exp_q.delete(); aw_id_q.delete(); ar_id_q.delete(); exp_id = '0;
    @(negedge clk); @(negedge clk);
    rst = 0; b_en = 1; r_en = 1;
    issue(0, 2'd2, 32'h108, 32'h0, 2'b01, 32'h1000_0042);
    drain();
    checks++;
    if (last_arid !== 4'h0) begin errors++; $display("FAIL midrst_id got %0h want 0", last_arid); end
    idle_for(10, "midrst_stray");
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    test_reset();
    test_word();
    test_byte_half();
    test_back_to_back();
    test_reorder();
    test_misaligned();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
